// File: rtl/dphy_rx_hs_sequencer.sv
// D-PHY RX lane sequencer: LP line decode, SoT walk, HS-enable window,
// end-of-transmission, entry error and HS timeout reporting.
module dphy_rx_hs_sequencer #(
    parameter int LP_FILTER      = 2,
    parameter int SETTLE_CYCLES  = 6,
    parameter int TIMEOUT_CYCLES = 40000
) (
    input  logic        dphy_clk,
    input  logic        areset,
    input  logic        enable,
    input  logic        lp_p,
    input  logic        lp_n,
    output logic        hs_en,
    output logic        align_rst,
    output logic        sot,
    output logic        eot,
    output logic        err_sot,
    output logic        err_timeout,
    output logic [15:0] burst_count,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        STOP     = 3'd0,
        HS_RQST  = 3'd1,
        HS_PREP  = 3'd2,
        HS_RX    = 3'd3,
        ESC_WAIT = 3'd4
    } state_t;

    localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [15:0] TO_LAST     = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  FILT        = 4'(LP_FILTER);

    logic [1:0]  meta;
    logic [1:0]  sync;
    logic [1:0]  sync_q;
    logic [3:0]  run_q;
    logic [3:0]  run_d;
    logic [1:0]  lp_code;

    state_t      state;
    state_t      next;
    logic [7:0]  settle_q;
    logic [15:0] to_q;
    logic [15:0] burst_q;
    logic        sot_d;
    logic        eot_d;
    logic        err_sot_d;
    logic        err_to_d;

    always_ff @(posedge dphy_clk or posedge areset) begin
        if (areset) begin
            meta <= 2'b11;
            sync <= 2'b11;
        end else begin
            meta <= {lp_p, lp_n};
            sync <= meta;
        end
    end

    // run_d = number of consecutive cycles the current sync code has held
    always_comb begin
        run_d = 4'd1;
        if (sync == sync_q) begin
            run_d = (run_q == 4'hf) ? run_q : run_q + 4'd1;
        end
    end

    always_ff @(posedge dphy_clk or posedge areset) begin
        if (areset) begin
            sync_q  <= 2'b11;
            run_q   <= 4'd0;
            lp_code <= 2'b11;
        end else begin
            sync_q <= sync;
            run_q  <= run_d;
            if (run_d >= FILT) begin
                lp_code <= sync;
            end
        end
    end

    always_ff @(posedge dphy_clk or posedge areset) begin
        if (areset) begin
            state       <= STOP;
            settle_q    <= 8'd0;
            to_q        <= 16'd0;
            sot         <= 1'b0;
            eot         <= 1'b0;
            err_sot     <= 1'b0;
            err_timeout <= 1'b0;
            burst_q     <= 16'd0;
        end else begin
            state       <= next;
            settle_q    <= (state == HS_PREP && next == HS_PREP) ?
                           settle_q + 8'd1 : 8'd0;
            to_q        <= (state == HS_RX && next == HS_RX) ?
                           to_q + 16'd1 : 16'd0;
            sot         <= sot_d;
            eot         <= eot_d;
            err_sot     <= err_sot_d;
            err_timeout <= err_to_d;
            if (sot_d) begin
                burst_q <= burst_q + 16'd1;
            end
        end
    end

    always_comb begin
        next      = state;
        err_sot_d = 1'b0;
        err_to_d  = 1'b0;
        if (!enable) begin
            next = STOP;
        end else begin
            unique case (state)
                STOP: begin
                    case (lp_code)
                        2'b01: next = HS_RQST;
                        2'b10: next = ESC_WAIT;
                        2'b00: begin
                            next      = ESC_WAIT;
                            err_sot_d = 1'b1;
                        end
                        default: next = STOP;
                    endcase
                end
                HS_RQST: begin
                    case (lp_code)
                        2'b00: next = HS_PREP;
                        2'b11: begin
                            next      = STOP;
                            err_sot_d = 1'b1;
                        end
                        2'b10: begin
                            next      = ESC_WAIT;
                            err_sot_d = 1'b1;
                        end
                        default: next = HS_RQST;
                    endcase
                end
                HS_PREP: begin
                    if (lp_code == 2'b11) begin
                        next      = STOP;
                        err_sot_d = 1'b1;
                    end else if (lp_code != 2'b00) begin
                        next      = ESC_WAIT;
                        err_sot_d = 1'b1;
                    end else if (settle_q == SETTLE_LAST) begin
                        next = HS_RX;
                    end
                end
                HS_RX: begin
                    // LP-11 takes precedence over a coincident timeout
                    if (lp_code == 2'b11) begin
                        next = STOP;
                    end else if (to_q == TO_LAST) begin
                        next     = ESC_WAIT;
                        err_to_d = 1'b1;
                    end
                end
                ESC_WAIT: begin
                    if (lp_code == 2'b11) begin
                        next = STOP;
                    end
                end
                default: next = STOP;
            endcase
        end
        sot_d = (next == HS_RX) && (state != HS_RX);
        eot_d = (state == HS_RX) && (next != HS_RX);
    end

    always_comb begin
        hs_en       = (state == HS_RX);
        align_rst   = (state != HS_RX);
        dbg_state   = state;
        burst_count = burst_q;
    end

endmodule

// File: tb/tb_dphy_rx_hs_sequencer.sv
// Randomised and directed bench for dphy_rx_hs_sequencer against a
// pin-history / dwell-time reference model.
module tb_dphy_rx_hs_sequencer;

    localparam int LPF = 2;
    localparam int SET = 6;
    localparam int TO  = 100;

    logic        clk = 1'b0;
    logic        areset = 1'b0;
    logic        enable = 1'b0;
    logic        lp_p = 1'b1;
    logic        lp_n = 1'b1;
    logic        hs_en;
    logic        align_rst;
    logic        sot;
    logic        eot;
    logic        err_sot;
    logic        err_timeout;
    logic [15:0] burst_count;
    logic [2:0]  dbg_state;

    dphy_rx_hs_sequencer #(
        .LP_FILTER(LPF),
        .SETTLE_CYCLES(SET),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .dphy_clk(clk),
        .areset(areset),
        .enable(enable),
        .lp_p(lp_p),
        .lp_n(lp_n),
        .hs_en(hs_en),
        .align_rst(align_rst),
        .sot(sot),
        .eot(eot),
        .err_sot(err_sot),
        .err_timeout(err_timeout),
        .burst_count(burst_count),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // reference model: line code is the pin value seen 2 edges ago once
    // it has been identical for LPF samples; states track dwell time
    int          m_state;
    int          m_in;
    logic [1:0]  m_lp;
    logic        m_sot, m_eot, m_esot, m_eto;
    logic [15:0] m_burst;
    logic [1:0]  hist[$];

    function automatic void model_reset();
        m_state = 0;
        m_in    = 0;
        m_lp    = 2'b11;
        m_sot   = 0;
        m_eot   = 0;
        m_esot  = 0;
        m_eto   = 0;
        m_burst = 0;
        hist.delete();
        for (int i = 0; i < 2 + LPF; i++) hist.push_back(2'b11);
    endfunction

    function automatic void model_step();
        int ns;
        bit es, et, same;
        ns = m_state;
        es = 0;
        et = 0;
        m_in++;
        if (!enable) ns = 0;
        else begin
            case (m_state)
                0: begin
                    if (m_lp == 2'b01) ns = 1;
                    else if (m_lp == 2'b10) ns = 4;
                    else if (m_lp == 2'b00) begin ns = 4; es = 1; end
                end
                1: begin
                    if (m_lp == 2'b00) ns = 2;
                    else if (m_lp == 2'b11) begin ns = 0; es = 1; end
                    else if (m_lp == 2'b10) begin ns = 4; es = 1; end
                end
                2: begin
                    if (m_lp == 2'b11) begin ns = 0; es = 1; end
                    else if (m_lp != 2'b00) begin ns = 4; es = 1; end
                    else if (m_in == SET) ns = 3;
                end
                3: begin
                    if (m_lp == 2'b11) ns = 0;
                    else if (m_in == TO) begin ns = 4; et = 1; end
                end
                default: if (m_lp == 2'b11) ns = 0;
            endcase
        end
        m_sot  = (ns == 3) && (m_state != 3);
        m_eot  = (m_state == 3) && (ns != 3);
        m_esot = es;
        m_eto  = et;
        if (m_sot) m_burst++;
        if (ns != m_state) m_in = 0;
        m_state = ns;
        hist.push_front({lp_p, lp_n});
        void'(hist.pop_back());
        same = 1;
        for (int i = 3; i <= 1 + LPF; i++) if (hist[i] != hist[2]) same = 0;
        if (same) m_lp = hist[2];
    endfunction

    function automatic logic [31:0] exp_vec();
        return {7'd0, m_state == 3, m_state != 3, m_sot, m_eot, m_esot,
                m_eto, 3'(m_state), m_burst};
    endfunction

    function automatic logic [31:0] got_vec();
        return {7'd0, hs_en, align_rst, sot, eot, err_sot, err_timeout,
                dbg_state, burst_count};
    endfunction

    int n_prep, n_rx, n_sot, n_eot, n_esot, n_eto;

    task automatic clr();
        n_prep = 0; n_rx = 0; n_sot = 0;
        n_eot = 0; n_esot = 0; n_eto = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        if (!areset) model_step();
        @(negedge clk);
        chk("outs", got_vec(), exp_vec());
        n_prep += int'(dbg_state == 3'd2);
        n_rx   += int'(hs_en);
        n_sot  += int'(sot);
        n_eot  += int'(eot);
        n_esot += int'(err_sot);
        n_eto  += int'(err_timeout);
    endtask

    task automatic hold(input logic [1:0] code, input int n);
        {lp_p, lp_n} = code;
        repeat (n) cyc();
    endtask

    initial begin
        int r;
        model_reset();
        clr();
        #2 areset = 1'b1;
        #1;
        chk("rst_const", got_vec(), 32'h0080_0000);
        repeat (3) @(negedge clk);
        areset = 1'b0;
        enable = 1'b1;
        hold(2'b11, 5);

        // clean SoT / EoT
        clr();
        hold(2'b01, 10);
        hold(2'b00, 50);
        chk("clean_prep_len", 32'(n_prep), 32'(SET));
        chk("clean_sot", 32'(n_sot), 1);
        hold(2'b11, 10);
        chk("clean_eot", 32'(n_eot), 1);
        chk("clean_burst", 32'(burst_count), 1);
        chk("clean_hs_off", 32'(hs_en), 0);

        // glitch rejection
        clr();
        hold(2'b01, 1);
        hold(2'b11, 10);
        chk("glitch_prep", 32'(n_prep + n_rx + n_sot + n_esot), 0);
        chk("glitch_state", 32'(dbg_state), 0);

        // illegal 11 -> 00
        clr();
        hold(2'b00, 10);
        chk("ill1_err", 32'(n_esot), 1);
        chk("ill1_state", 32'(dbg_state), 4);
        hold(2'b11, 10);
        chk("ill1_back", 32'(dbg_state), 0);

        // aborted request 11 -> 01 -> 11
        clr();
        hold(2'b01, 10);
        hold(2'b11, 10);
        chk("ill2_err", 32'(n_esot), 1);
        chk("ill2_state", 32'(dbg_state), 0);

        // HS_RX timeout
        clr();
        hold(2'b01, 10);
        hold(2'b00, 130);
        chk("to_rx_len", 32'(n_rx), 32'(TO));
        chk("to_err", 32'(n_eto), 1);
        chk("to_eot", 32'(n_eot), 1);
        chk("to_state", 32'(dbg_state), 4);
        chk("to_hs", 32'(hs_en), 0);
        hold(2'b00, 30);
        chk("to_no_resot", 32'(n_sot), 1);
        hold(2'b11, 10);

        // enable drop mid HS_RX
        clr();
        hold(2'b01, 10);
        hold(2'b00, 30);
        enable = 1'b0;
        cyc();
        chk("en_eot", 32'(eot), 1);
        chk("en_state", 32'(dbg_state), 0);
        hold(2'b00, 5);
        hold(2'b11, 10);
        chk("en_no_err", 32'(n_esot + n_eto), 0);
        enable = 1'b1;
        hold(2'b11, 5);

        // areset mid HS_PREP
        clr();
        hold(2'b01, 10);
        hold(2'b00, 6);
        chk("ar_in_prep", 32'(dbg_state), 2);
        areset = 1'b1;
        #1;
        model_reset();
        chk("ar_immediate", got_vec(), 32'h0080_0000);
        hold(2'b00, 3);
        {lp_p, lp_n} = 2'b11;
        areset = 1'b0;
        hold(2'b11, 10);
        chk("ar_no_pulse", 32'(n_sot + n_eot), 0);

        // burst counter wrap
        force dut.burst_q = 16'hffff;
        #1;
        release dut.burst_q;
        m_burst = 16'hffff;
        hold(2'b01, 10);
        hold(2'b00, 20);
        hold(2'b11, 10);
        chk("wrap", 32'(burst_count), 0);

        // randomised traffic
        for (int s = 0; s < 300; s++) begin
            r = $urandom_range(0, 3);
            case (r)
                0: hold(2'($urandom), $urandom_range(1, 12));
                1: begin
                    hold(2'b01, $urandom_range(1, 8));
                    if ($urandom_range(0, 3) == 0)
                        hold(2'b00, $urandom_range(90, 130));
                    else
                        hold(2'b00, $urandom_range(1, 40));
                    hold(2'b11, $urandom_range(1, 8));
                end
                2: begin
                    enable = 1'b0;
                    hold(2'($urandom), $urandom_range(1, 5));
                    enable = 1'b1;
                end
                default: begin
                    hold(2'($urandom), 1);
                    hold(2'($urandom), $urandom_range(1, 4));
                end
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
